// File: rtl/toggle_pulse_tx.sv
// Transmit side of a toggle-based pulse crossing: each accepted clk-domain
// event becomes one level flip on toggle_out, paced by the echoed acknowledge.
module toggle_pulse_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pulse_in,
  input  logic                   ack_toggle_in,
  output logic                   toggle_out,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] pending_count,
  output logic                   overflow
);

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic                   toggle_q, toggle_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overflow_q, overflow_d;

  logic ack_sync;
  logic count_nz;
  logic launch;

  // Only the last synchronizer stage is trusted; earlier stages may be metastable.
  assign ack_sync = ack_sync_q[SYNC_STAGES-1];
  assign count_nz = (count_q != '0);
  assign launch   = (state_q == IDLE) && (pulse_in || count_nz);

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    toggle_d   = toggle_q;
    count_d    = count_q;
    overflow_d = 1'b0;
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_toggle_in};

    case (state_q)
      IDLE: begin
        if (launch) begin
          toggle_d = ~toggle_q;
          state_d  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_sync == toggle_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A launch with a concurrent pulse swaps the oldest queued event for the
    // new one, so the count is unchanged.
    if (launch) begin
      if (!pulse_in) count_d = count_q - COUNT_WIDTH'(1);
    end else if (pulse_in) begin
      if (count_q != COUNT_MAX) count_d = count_q + COUNT_WIDTH'(1);
      else                      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours, which the synchronizer shift relies on.
    if (reset) begin
      state_q    <= IDLE;
      ack_sync_q <= '0;
      toggle_q   <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_sync_q <= ack_sync_d;
      toggle_q   <= toggle_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign toggle_out    = toggle_q;
  assign pending_count = count_q;
  assign overflow      = overflow_q;
  assign busy          = (state_q == WAIT_ACK) || count_nz;

endmodule

// File: tb/tb_toggle_pulse_tx.sv
// Directed bench for toggle_pulse_tx: loopback, delayed-ack and stuck-ack
// (narrow counter) scenarios with hand-computed expectations.
module tb_toggle_pulse_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       pulse_in;
  logic       loopback;
  logic       ack_man;
  logic       ack_in;
  logic       toggle_out;
  logic       busy;
  logic [3:0] pending_count;
  logic       overflow;

  logic       reset2;
  logic       pulse2;
  logic       toggle2;
  logic       busy2;
  logic [1:0] count2;
  logic       ovf2;

  int n_vec = 0;
  int n_err = 0;

  int   flip_cnt = 0;
  int   ovf_cnt  = 0;
  logic tog_prev = 1'b0;

  always #5 clk = ~clk;

  assign ack_in = loopback ? toggle_out : ack_man;

  toggle_pulse_tx #(.SYNC_STAGES(2), .COUNT_WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .pulse_in     (pulse_in),
    .ack_toggle_in(ack_in),
    .toggle_out   (toggle_out),
    .busy         (busy),
    .pending_count(pending_count),
    .overflow     (overflow)
  );

  toggle_pulse_tx #(.SYNC_STAGES(2), .COUNT_WIDTH(2)) dut_stuck (
    .clk          (clk),
    .reset        (reset2),
    .pulse_in     (pulse2),
    .ack_toggle_in(1'b0),
    .toggle_out   (toggle2),
    .busy         (busy2),
    .pending_count(count2),
    .overflow     (ovf2)
  );

  // Observers on the main instance: count toggle flips and overflow pulses.
  always @(negedge clk) begin
    if (toggle_out !== tog_prev) flip_cnt++;
    tog_prev = toggle_out;
    if (overflow) ovf_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    pulse_in = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  int flip_base;
  int ovf_base;

  initial begin
    reset    = 1'b1;
    pulse_in = 1'b0;
    loopback = 1'b1;
    ack_man  = 1'b0;
    reset2   = 1'b1;
    pulse2   = 1'b0;
    step();
    step();

    // Reset state, with pulse_in high to show it is ignored during reset.
    pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
    chk("rst_toggle", toggle_out, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_count",  pending_count, 0);
    chk("rst_ovf",    overflow, 0);
    reset = 1'b0;
    step();
    chk("rst_release_toggle", toggle_out, 0);

    // Single event, loopback.
    pulse_in = 1'b1;
    step();                                 // edge 0
    pulse_in = 1'b0;
    chk("single_e0_toggle", toggle_out, 1);
    chk("single_e0_busy",   busy, 1);
    chk("single_e0_count",  pending_count, 0);
    step();
    chk("single_e1_busy", busy, 1);
    step();
    chk("single_e2_busy", busy, 1);
    step();                                 // edge 3
    chk("single_e3_busy",   busy, 0);
    chk("single_e3_toggle", toggle_out, 1);

    // Burst of three pulses, loopback.
    do_reset();
    flip_base = flip_cnt;
    ovf_base  = ovf_cnt;
    pulse_in  = 1'b1;
    step();                                 // edge 0
    chk("burst_e0_toggle", toggle_out, 1);
    chk("burst_e0_count",  pending_count, 0);
    step();                                 // edge 1
    chk("burst_e1_count", pending_count, 1);
    step();                                 // edge 2
    pulse_in = 1'b0;
    chk("burst_e2_count", pending_count, 2);
    step();                                 // edge 3
    chk("burst_e3_toggle", toggle_out, 1);
    step();                                 // edge 4
    chk("burst_e4_toggle", toggle_out, 0);
    chk("burst_e4_count",  pending_count, 1);
    for (int i = 0; i < 3; i++) step();
    chk("burst_e7_toggle", toggle_out, 0);
    step();                                 // edge 8
    chk("burst_e8_toggle", toggle_out, 1);
    chk("burst_e8_count",  pending_count, 0);
    step();
    step();                                 // edge 10
    chk("burst_e10_busy", busy, 1);
    step();                                 // edge 11
    chk("burst_e11_busy",  busy, 0);
    chk("burst_flips",     flip_cnt - flip_base, 3);
    chk("burst_no_ovf",    ovf_cnt - ovf_base, 0);

    // Coincident launch and pulse with two events queued.
    do_reset();
    flip_base = flip_cnt;
    pulse_in  = 1'b1;
    step();
    step();
    step();                                 // edge 2
    pulse_in = 1'b0;
    chk("coinc_setup_count", pending_count, 2);
    step();                                 // edge 3: back in IDLE
    chk("coinc_e3_count", pending_count, 2);
    pulse_in = 1'b1;
    step();                                 // edge 4: launch + pulse
    pulse_in = 1'b0;
    chk("coinc_e4_count",  pending_count, 2);
    chk("coinc_e4_toggle", toggle_out, 0);
    for (int i = 0; i < 4; i++) step();     // edge 8
    chk("coinc_e8_count", pending_count, 1);
    for (int i = 0; i < 4; i++) step();     // edge 12
    chk("coinc_e12_count", pending_count, 0);
    for (int i = 0; i < 3; i++) step();     // edge 15
    chk("coinc_e15_busy", busy, 0);
    chk("coinc_flips",    flip_cnt - flip_base, 4);

    // Reset in WAIT_ACK with two events queued.
    do_reset();
    pulse_in = 1'b1;
    step();
    step();
    step();                                 // edge 2
    pulse_in = 1'b0;
    chk("rmid_setup_count", pending_count, 2);
    reset = 1'b1;
    step();
    chk("rmid_toggle", toggle_out, 0);
    chk("rmid_count",  pending_count, 0);
    chk("rmid_busy",   busy, 0);
    chk("rmid_ovf",    overflow, 0);
    reset    = 1'b0;
    pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
    chk("rmid_fresh_toggle", toggle_out, 1);
    for (int i = 0; i < 3; i++) step();
    chk("rmid_fresh_idle", busy, 0);

    // Delayed acknowledge: echo appears ten cycles after the launch.
    loopback = 1'b0;
    ack_man  = 1'b0;
    do_reset();
    flip_base = flip_cnt;
    pulse_in  = 1'b1;
    step();                                 // edge 0
    chk("dly_e0_toggle", toggle_out, 1);
    step();                                 // edge 1
    pulse_in = 1'b0;
    chk("dly_e1_count", pending_count, 1);
    for (int i = 0; i < 9; i++) step();     // edge 10
    chk("dly_e10_toggle", toggle_out, 1);
    chk("dly_e10_count",  pending_count, 1);
    ack_man = 1'b1;
    step();
    step();                                 // edge 12
    chk("dly_e12_toggle", toggle_out, 1);
    step();                                 // edge 13: IDLE
    chk("dly_e13_toggle", toggle_out, 1);
    chk("dly_e13_count",  pending_count, 1);
    step();                                 // edge 14: queued launch
    chk("dly_e14_toggle", toggle_out, 0);
    chk("dly_e14_count",  pending_count, 0);
    ack_man = 1'b0;
    step();
    step();                                 // edge 16
    chk("dly_e16_busy", busy, 1);
    step();                                 // edge 17
    chk("dly_e17_busy", busy, 0);
    chk("dly_flips",    flip_cnt - flip_base, 2);

    // Stuck ack on the narrow-counter instance: six consecutive pulses.
    reset2 = 1'b0;
    pulse2 = 1'b1;
    step();                                 // edge 0
    chk("stuck_e0_toggle", toggle2, 1);
    chk("stuck_e0_count",  count2, 0);
    step();
    chk("stuck_e1_count", count2, 1);
    step();
    chk("stuck_e2_count", count2, 2);
    step();
    chk("stuck_e3_count", count2, 3);
    chk("stuck_e3_ovf",   ovf2, 0);
    step();
    chk("stuck_e4_count", count2, 3);
    chk("stuck_e4_ovf",   ovf2, 1);
    step();                                 // edge 5: last pulse
    pulse2 = 1'b0;
    chk("stuck_e5_count", count2, 3);
    chk("stuck_e5_ovf",   ovf2, 1);
    step();
    chk("stuck_e6_ovf",    ovf2, 0);
    chk("stuck_e6_busy",   busy2, 1);
    chk("stuck_e6_toggle", toggle2, 1);
    for (int i = 0; i < 4; i++) step();
    chk("stuck_hold_toggle", toggle2, 1);
    chk("stuck_hold_count",  count2, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
